// File: rtl/sequenciador_notas_pkg.sv
// ---------------------------------------------------------------------------
// sequenciador_pkg
// Shared definitions for the melody sequencer:
//   state_t     - sequencer FSM states
//   *_BIT/MSB   - field positions inside an 8-bit table entry
//                 {tom, note[2:0], dur[3:0]}
//   END_DUR     - duration value that marks the end of the melody
//   entry_dur   - extracts the duration field from an entry
// ---------------------------------------------------------------------------
package sequenciador_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PLAY   = 2'd1,
        GAP    = 2'd2,
        PAUSED = 2'd3
    } state_t;

    localparam int TOM_BIT  = 7;
    localparam int NOTE_MSB = 6;
    localparam int NOTE_LSB = 4;
    localparam int DUR_MSB  = 3;
    localparam int DUR_LSB  = 0;

    localparam logic [3:0] END_DUR = 4'd0;

    function automatic logic [3:0] entry_dur(input logic [7:0] entry);
        return entry[DUR_MSB:DUR_LSB];
    endfunction

endpackage

// File: rtl/sequenciador_notas_divisor_tempo.sv
// ---------------------------------------------------------------------------
// divisor_tempo
// Beat prescaler. Counts 0..TICK_DIV-1 while run is high and emits a
// one-cycle tick on the last count. The count holds while run is low and
// returns to 0 whenever clear is high (clear wins over run).
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset
//   run        - advance the count this cycle
//   clear      - force the count back to 0
//   tick       - high for the cycle in which the count is TICK_DIV-1 and run
// ---------------------------------------------------------------------------
module divisor_tempo #(
    parameter int TICK_DIV = 6250000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    input  logic clear,
    output logic tick
);

    localparam int CW = $clog2(TICK_DIV);
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (run) begin
            cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    assign tick = run && (cnt_q == LAST);

endmodule

// File: rtl/sequenciador_notas.sv
// ---------------------------------------------------------------------------
// sequenciador_notas
// Melody sequencer feeding the 7-segment note display decoder. A table of
// SEQ_LEN entries {tom, note[2:0], dur[3:0]} is played one entry at a time:
// each note sounds for dur beat ticks, followed by GAP_TICKS silent ticks.
// dur = 0 marks the end of the melody.
// Ports:
//   clk, rst_n                  - clock, asynchronous active-low reset
//   start / pause / stop        - single-cycle control pulses
//                                 (priority stop > start > pause)
//   loop_en                     - level: restart at entry 0 at the end
//   wr_en / wr_addr / wr_data   - table write port (any state)
//   NOTAS, TOM                  - note code / tone modifier to the decoder
//   note_on                     - high while a note is sounding
//   seq_pos                     - index of the current entry
//   busy                        - high in any state other than IDLE
//   done                        - one-cycle pulse at natural end of melody
//   dbg_state                   - current FSM state, for observation
// All outputs are registered.
// ---------------------------------------------------------------------------
module sequenciador_notas
    import sequenciador_pkg::*;
#(
    parameter int TICK_DIV  = 6250000,
    parameter int SEQ_LEN   = 16,
    parameter int GAP_TICKS = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic                       pause,
    input  logic                       stop,
    input  logic                       loop_en,
    input  logic                       wr_en,
    input  logic [$clog2(SEQ_LEN)-1:0] wr_addr,
    input  logic [7:0]                 wr_data,
    output logic [2:0]                 NOTAS,
    output logic                       TOM,
    output logic                       note_on,
    output logic [$clog2(SEQ_LEN)-1:0] seq_pos,
    output logic                       busy,
    output logic                       done,
    output state_t                     dbg_state
);

    localparam int AW = $clog2(SEQ_LEN);
    localparam int GW = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_TICKS - 1);
    localparam logic [AW-1:0] POS_LAST = AW'(SEQ_LEN - 1);

    logic [7:0]    seq_table [SEQ_LEN];

    state_t        state_q, state_d, ret_q, ret_d, nat_state;
    logic [AW-1:0] pos_q, pos_d, pos_next, load_addr;
    logic [3:0]    rem_q, rem_d;
    logic [GW-1:0] gap_q, gap_d;
    logic          load, end_seq;
    logic [7:0]    entry0, entry_next;
    logic          tick, presc_run, presc_clear;
    logic          note_on_d, busy_d, done_d, tom_d;
    logic [2:0]    notas_d;

    // Table: asynchronous read, so a fetch in the same cycle as a write to
    // the same address sees the old contents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SEQ_LEN; i++) seq_table[i] <= '0;
        end else if (wr_en) begin
            seq_table[wr_addr] <= wr_data;
        end
    end

    assign pos_next   = pos_q + 1'b1;
    assign entry0     = seq_table[0];
    assign entry_next = seq_table[pos_next];

    // Prescaler runs only while playing or in a gap; it is held at 0 in IDLE
    // so playback always starts on a fresh beat, and is frozen in PAUSED.
    assign presc_run   = (state_q == PLAY) || (state_q == GAP);
    assign presc_clear = (state_q == IDLE) || stop;

    divisor_tempo #(
        .TICK_DIV (TICK_DIV)
    ) u_divisor_tempo (
        .clk   (clk),
        .rst_n (rst_n),
        .run   (presc_run),
        .clear (presc_clear),
        .tick  (tick)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ret_q   <= IDLE;
            pos_q   <= '0;
            rem_q   <= '0;
            gap_q   <= '0;
            NOTAS   <= '0;
            TOM     <= 1'b0;
            note_on <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            ret_q   <= ret_d;
            pos_q   <= pos_d;
            rem_q   <= rem_d;
            gap_q   <= gap_d;
            NOTAS   <= notas_d;
            TOM     <= tom_d;
            note_on <= note_on_d;
            busy    <= busy_d;
            done    <= done_d;
        end
    end

    // Next state. nat_state is where playback would go without a pause; a
    // pause arriving in the same cycle still lets that step happen (a tick
    // is never lost) and parks it as the return state instead.
    always_comb begin
        nat_state = state_q;
        ret_d     = ret_q;
        pos_d     = pos_q;
        rem_d     = rem_q;
        gap_d     = gap_q;
        load      = 1'b0;
        load_addr = '0;
        end_seq   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (entry_dur(entry0) != END_DUR) load = 1'b1;
                    else                              end_seq = 1'b1;
                end
            end
            PLAY: begin
                if (tick) begin
                    rem_d = rem_q - 4'd1;
                    if (rem_q == 4'd1) begin
                        nat_state = GAP;
                        gap_d     = '0;
                    end
                end
            end
            GAP: begin
                if (tick) begin
                    if (gap_q == GAP_LAST) begin
                        if (pos_q != POS_LAST && entry_dur(entry_next) != END_DUR) begin
                            load      = 1'b1;
                            load_addr = pos_next;
                        end else if (loop_en && entry_dur(entry0) != END_DUR) begin
                            load = 1'b1;
                        end else begin
                            end_seq = 1'b1;
                        end
                    end else begin
                        gap_d = gap_q + 1'b1;
                    end
                end
            end
            PAUSED: begin
                if (pause) nat_state = ret_q;
            end
            default: nat_state = IDLE;
        endcase

        if (load) begin
            nat_state = PLAY;
            pos_d     = load_addr;
            rem_d     = entry_dur(seq_table[load_addr]);
        end
        if (end_seq) begin
            nat_state = IDLE;
            pos_d     = '0;
        end

        state_d = nat_state;
        if (pause && (state_q == PLAY || state_q == GAP) && !end_seq) begin
            state_d = PAUSED;
            ret_d   = nat_state;
        end

        if (stop) begin
            state_d = IDLE;
            pos_d   = '0;
            rem_d   = '0;
            load    = 1'b0;
            end_seq = 1'b0;
        end
    end

    // Output values for the next cycle. NOTAS/TOM change only when a new
    // entry is latched, so they hold through gaps, pauses and stops.
    always_comb begin
        note_on_d = (state_d == PLAY);
        busy_d    = (state_d != IDLE);
        done_d    = end_seq;
        notas_d   = NOTAS;
        tom_d     = TOM;
        if (load) begin
            notas_d = seq_table[load_addr][NOTE_MSB:NOTE_LSB];
            tom_d   = seq_table[load_addr][TOM_BIT];
        end
    end

    assign seq_pos   = pos_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_sequenciador_notas.sv
// ---------------------------------------------------------------------------
// tb_sequenciador_notas
// Directed bench. A timeline model turns the table contents into the
// expected per-cycle output stream (note cycles, gap cycles, done pulse),
// then pause and stop pulses are applied to that stream as shifts and
// truncations. The compare process checks every cycle of each scenario
// against the queue; literal checks pin individual cycles.
// Record layout: {busy, done, note_on, TOM, NOTAS[2:0], seq_pos[3:0]}
// ---------------------------------------------------------------------------
module tb_sequenciador_notas;
    import sequenciador_pkg::*;

    localparam int TD   = 4;
    localparam int SL   = 16;
    localparam int GT   = 1;
    localparam int MAXL = 64;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0, pause = 1'b0, stop = 1'b0, loop_en = 1'b0;
    logic       wr_en = 1'b0;
    logic [3:0] wr_addr = '0;
    logic [7:0] wr_data = '0;
    logic [2:0] NOTAS;
    logic       TOM, note_on, busy, done;
    logic [3:0] seq_pos;
    state_t     dbg_state;

    int n_pass  = 0;
    int n_total = 0;

    logic [10:0] exp_q[$];
    logic [10:0] snap [0:MAXL];
    int          cmp_idx = 1;

    logic [7:0]  tbl_m [SL];
    logic [2:0]  last_notas = '0;
    logic        last_tom = 1'b0;
    logic [10:0] tl [0:MAXL];
    logic [10:0] ov [0:MAXL];

    sequenciador_notas #(
        .TICK_DIV  (TD),
        .SEQ_LEN   (SL),
        .GAP_TICKS (GT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .pause     (pause),
        .stop      (stop),
        .loop_en   (loop_en),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .NOTAS     (NOTAS),
        .TOM       (TOM),
        .note_on   (note_on),
        .seq_pos   (seq_pos),
        .busy      (busy),
        .done      (done),
        .dbg_state (dbg_state)
    );

    // Clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [10:0] mk(input logic b, input logic d, input logic o,
                                       input logic t, input logic [2:0] n,
                                       input logic [3:0] p);
        return {b, d, o, t, n, p};
    endfunction

    task automatic chk(input string name, input logic [10:0] got, input logic [10:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got busy=%b done=%b on=%b tom=%b notas=%0d pos=%0d, want busy=%b done=%b on=%b tom=%b notas=%0d pos=%0d",
                      name, got[10], got[9], got[8], got[7], got[6:4], got[3:0],
                      exp[10], exp[9], exp[8], exp[7], exp[6:4], exp[3:0]);
    endtask

    task automatic chk_val(input string name, input int got, input int exp);
        n_total++;
        if (got == exp) n_pass++;
        else $display("FAIL %s got %0d want %0d", name, got, exp);
    endtask

    // Scoreboard: one expected record per cycle while the queue is non-empty
    always @(posedge clk) begin
        #2;
        if (exp_q.size() > 0) begin
            logic [10:0] e, g;
            e = exp_q.pop_front();
            g = {busy, done, note_on, TOM, NOTAS, seq_pos};
            if (cmp_idx <= MAXL) snap[cmp_idx] = g;
            chk($sformatf("cycle%0d", cmp_idx), g, e);
            cmp_idx++;
        end else begin
            cmp_idx = 1;
        end
    end

    // Model: expected outputs for cycles 0..len after a start pulse at cycle 0
    task automatic gen_timeline(input int len, input bit lp);
        int k, idx;
        logic [2:0] n;
        logic t;
        bit fin, ended;
        n = last_notas; t = last_tom; fin = 1'b0; ended = 1'b0; idx = 0; k = 1;
        tl[0] = mk(1'b0, 1'b0, 1'b0, t, n, 4'd0);
        while (k <= len) begin
            if (fin || ended || tbl_m[idx][3:0] == 4'd0) begin
                tl[k] = mk(1'b0, !fin, 1'b0, t, n, 4'd0);
                fin = 1'b1;
                k++;
            end else begin
                n = tbl_m[idx][6:4];
                t = tbl_m[idx][7];
                for (int c = 0; c < int'(tbl_m[idx][3:0]) * TD && k <= len; c++) begin
                    tl[k] = mk(1'b1, 1'b0, 1'b1, t, n, 4'(idx));
                    k++;
                end
                for (int c = 0; c < GT * TD && k <= len; c++) begin
                    tl[k] = mk(1'b1, 1'b0, 1'b0, t, n, 4'(idx));
                    k++;
                end
                if (idx == SL - 1 || tbl_m[idx + 1][3:0] == 4'd0) begin
                    if (lp) idx = 0;
                    else    ended = 1'b1;
                end else begin
                    idx++;
                end
            end
        end
    endtask

    // Driver: start at cycle 0, optional pause pulses at pa/pb, stop at ps
    // (-1 = none). Pausing freezes the stream at cycle pa+1 with note_on low
    // and resumes from that point, shifting the rest by pb-pa cycles.
    task automatic run_scen(input int len, input int pa, input int pb,
                            input int ps, input bit lp);
        gen_timeline(len, lp);
        for (int k = 0; k <= len; k++) begin
            if (pa >= 0 && k > pa && k <= pb)
                ov[k] = {tl[pa + 1][10:9], 1'b0, tl[pa + 1][7:0]};
            else if (pa >= 0 && k > pb)
                ov[k] = tl[k - (pb - pa)];
            else
                ov[k] = tl[k];
        end
        if (ps >= 0)
            for (int k = ps + 1; k <= len; k++)
                ov[k] = mk(1'b0, 1'b0, 1'b0, ov[ps][7], ov[ps][6:4], 4'd0);

        @(negedge clk);
        loop_en = lp;
        for (int k = 1; k <= len; k++) exp_q.push_back(ov[k]);
        for (int c = 0; c < len; c++) begin
            if (c > 0) @(negedge clk);
            start = (c == 0);
            pause = (c == pa || c == pb);
            stop  = (c == ps);
        end
        @(negedge clk);
        start = 1'b0; pause = 1'b0; stop = 1'b0; loop_en = 1'b0;
        for (int w = 0; w < 8 && exp_q.size() > 0; w++) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_total++;
            $display("FAIL drain: %0d expected records left unchecked", exp_q.size());
            exp_q.delete();
        end
        last_notas = ov[len][6:4];
        last_tom   = ov[len][7];
    endtask

    task automatic wr(input int a, input logic [7:0] d);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 4'(a); wr_data = d;
        tbl_m[a] = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < SL; i++) tbl_m[i] = '0;

        // Reset state
        repeat (3) @(negedge clk);
        chk_val("rst_note_on", int'(note_on), 0);
        chk_val("rst_busy", int'(busy), 0);
        chk_val("rst_done", int'(done), 0);
        chk_val("rst_notas", int'(NOTAS), 0);
        chk_val("rst_state_idle", int'(dbg_state == IDLE), 1);
        rst_n = 1'b1;

        // e0 = {0,3,2}, e1 = {1,5,1}, e2 = end
        wr(0, 8'h32); wr(1, 8'hD1); wr(2, 8'h00);

        // Plain playback
        run_scen(24, -1, -1, -1, 1'b0);
        chk_val("s1_c1_notas", int'(snap[1][6:4]), 3);
        chk_val("s1_c1_on", int'(snap[1][8]), 1);
        chk_val("s1_c8_on", int'(snap[8][8]), 1);
        chk_val("s1_c9_gap", int'(snap[9][8]), 0);
        chk_val("s1_c13_notas", int'(snap[13][6:4]), 5);
        chk_val("s1_c13_tom", int'(snap[13][7]), 1);
        chk_val("s1_c13_pos", int'(snap[13][3:0]), 1);
        chk_val("s1_c20_done", int'(snap[20][9]), 0);
        chk_val("s1_c21_done", int'(snap[21][9]), 1);
        chk_val("s1_c21_busy", int'(snap[21][10]), 0);
        chk_val("s1_c22_done", int'(snap[22][9]), 0);

        // Looping, stopped at cycle 44
        run_scen(45, -1, -1, 44, 1'b1);
        chk_val("s2_c21_on", int'(snap[21][8]), 1);
        chk_val("s2_c21_notas", int'(snap[21][6:4]), 3);
        chk_val("s2_c21_pos", int'(snap[21][3:0]), 0);
        chk_val("s2_c21_done", int'(snap[21][9]), 0);
        chk_val("s2_c41_on", int'(snap[41][8]), 1);
        chk_val("s2_c45_busy", int'(snap[45][10]), 0);

        // Pause at 3, resume at 13
        run_scen(36, 3, 13, -1, 1'b0);
        chk_val("s3_c4_on", int'(snap[4][8]), 0);
        chk_val("s3_c4_busy", int'(snap[4][10]), 1);
        chk_val("s3_c13_on", int'(snap[13][8]), 0);
        chk_val("s3_c14_on", int'(snap[14][8]), 1);
        chk_val("s3_c18_on", int'(snap[18][8]), 1);
        chk_val("s3_c19_on", int'(snap[19][8]), 0);
        chk_val("s3_c31_done", int'(snap[31][9]), 1);

        // Stop at 5, then replay
        run_scen(10, -1, -1, 5, 1'b0);
        chk_val("s4_c5_on", int'(snap[5][8]), 1);
        chk_val("s4_c6_on", int'(snap[6][8]), 0);
        chk_val("s4_c6_busy", int'(snap[6][10]), 0);
        chk_val("s4_c6_done", int'(snap[6][9]), 0);
        run_scen(24, -1, -1, -1, 1'b0);
        chk_val("s4_replay_notas", int'(snap[1][6:4]), 3);

        // Empty table: immediate done; start+stop together: nothing
        wr(0, 8'h00); wr(1, 8'h00);
        run_scen(4, -1, -1, -1, 1'b0);
        chk_val("s5_c1_done", int'(snap[1][9]), 1);
        chk_val("s5_c2_done", int'(snap[2][9]), 0);
        run_scen(4, -1, -1, 0, 1'b0);
        chk_val("s5_startstop_done", int'(snap[1][9]), 0);
        chk_val("s5_startstop_busy", int'(snap[1][10]), 0);

        // Reset during playback
        wr(0, 8'h32); wr(1, 8'hD1);
        run_scen(6, -1, -1, -1, 1'b0);
        chk_val("s6_c6_on", int'(snap[6][8]), 1);
        #1 rst_n = 1'b0;
        #1;
        chk_val("s6_rst_on", int'(note_on), 0);
        chk_val("s6_rst_busy", int'(busy), 0);
        chk_val("s6_rst_notas", int'(NOTAS), 0);
        chk_val("s6_rst_tom", int'(TOM), 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < SL; i++) tbl_m[i] = '0;
        last_notas = '0; last_tom = 1'b0;
        run_scen(3, -1, -1, -1, 1'b0);
        chk_val("s6_after_rst_done", int'(snap[1][9]), 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
